// File: rtl/cla_add_pipe.sv
// cla_add_pipe: two-stage pipelined adder, 4-bit carry-lookahead groups rippling within each half
module cla_add_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);
  localparam int H = WIDTH / 2;
  localparam int G = H / 4;
  // Returns {carry_out, sum} for one half; carries ripple group to group.
  function automatic logic [H:0] cla_half(input logic [H-1:0] x, input logic [H-1:0] y, input logic c);
    logic [H-1:0] g, p, sum;
    logic [G:0] gc;
    logic [3:0] gg, pp;
    logic [4:0] cc;
    g = x & y;
    p = x | y;
    sum = '0;
    gc = '0;
    gc[0] = c;
    for (int k = 0; k < G; k++) begin
      gg = g[4*k +: 4];
      pp = p[4*k +: 4];
      cc[0] = gc[k];
      cc[1] = gg[0] | (pp[0] & cc[0]);
      cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & cc[0]);
      cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) | (pp[2] & pp[1] & pp[0] & cc[0]);
      cc[4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) | (pp[3] & pp[2] & pp[1] & gg[0])
            | (pp[3] & pp[2] & pp[1] & pp[0] & cc[0]);
      sum[4*k +: 4] = x[4*k +: 4] ^ y[4*k +: 4] ^ cc[3:0];
      gc[k+1] = cc[4];
    end
    return {gc[G], sum};
  endfunction
  logic         v1, v2, adv1, adv2, c1;
  logic [H-1:0] lo1, ah1, bh1;
  logic [H:0]   lo_r, hi_r;
  assign adv2      = !v2 | out_ready;
  assign adv1      = !v1 | adv2;
  assign in_ready  = adv1;
  assign out_valid = v2;
  assign lo_r      = cla_half(a[H-1:0], b[H-1:0], ci);
  assign hi_r      = cla_half(ah1, bh1, c1);
  // Data registers load only with a valid operation so idle stages hold their last value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      c1  <= 1'b0;
      lo1 <= '0;
      ah1 <= '0;
      bh1 <= '0;
      s   <= '0;
      co  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      if (adv1) v1 <= in_valid;
      if (adv2) v2 <= v1;
      if (adv1 && in_valid) begin
        lo1 <= lo_r[H-1:0];
        c1  <= lo_r[H];
        ah1 <= a[WIDTH-1:H];
        bh1 <= b[WIDTH-1:H];
      end
      if (adv2 && v1) begin
        s   <= {hi_r[H-1:0], lo1};
        co  <= hi_r[H];
        ovf <= (ah1[H-1] == bh1[H-1]) && (hi_r[H-1] != ah1[H-1]);
      end
    end
  end
endmodule
